mult_pipe_ctrl: RTL

MULT_PIPE_CTRL -- requirements
Module: mult_pipe_ctrl

---
 rtl/vi_mult_pkg.sv | 20 ++
 rtl/mult_hazard_cmp.sv | 16 +
 rtl/mult_pipe_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/vi_mult_pkg.sv
// Shared types and constants for the multiply-pipe issue controller.
package vi_mult_pkg;
  localparam int MULT_STAGES = 5;
  localparam int REG_AW      = 5;

  // One in-flight multiply as seen by the issue logic.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
  } stage_t;

  // Population count of valid stages (0..MULT_STAGES).
  function automatic logic [2:0] count_valid(input stage_t [MULT_STAGES-1:0] s);
    logic [2:0] n;
    n = '0;
    for (int k = 0; k < MULT_STAGES; k++) n = n + 3'(s[k].valid);
    return n;
  endfunction
endpackage

// File: rtl/mult_hazard_cmp.sv
// Compares one register address against every multiply stage entry.
// match[k] is set when stage k+1 holds a live write to a nonzero addr.
module mult_hazard_cmp
  import vi_mult_pkg::*;
(
  input  logic [REG_AW-1:0]            addr,
  input  stage_t [MULT_STAGES-1:0]     stages,
  output logic [MULT_STAGES-1:0]       match
);

  for (genvar k = 0; k < MULT_STAGES; k++) begin : g_stg
    assign match[k] = (addr != '0) && stages[k].valid && stages[k].we &&
                      (stages[k].rd == addr);
  end

endmodule

// File: rtl/mult_pipe_ctrl.sv
// Issue/hazard controller for a 5-stage multiply pipe sharing the
// register-file write port with a fixed-latency ALU.
// Optional macro VI_MULT_FWD_EN: a source matching only stage 5 is
// bypassed instead of stalling; otherwise forward outputs are tied low.
module mult_pipe_ctrl
  import vi_mult_pkg::*;
#(
  parameter int ALU_WB_LAT = 3
) (
  input  logic                   clk_i,
  input  logic                   rsn_i,
  input  logic                   issue_valid_i,
  input  logic                   issue_is_mult_i,
  input  logic [REG_AW-1:0]      issue_rd_i,
  input  logic [REG_AW-1:0]      issue_rs1_i,
  input  logic [REG_AW-1:0]      issue_rs2_i,
  input  logic                   issue_we_i,
  input  logic                   flush_i,
  output logic                   issue_ready_o,
  output logic [MULT_STAGES-1:0] mult_kill_o,
  output logic                   wb_sel_mult_o,
  output logic                   fwd_mult5_rs1_o,
  output logic                   fwd_mult5_rs2_o,
  output logic [2:0]             inflight_cnt_o,
  output logic                   mult_busy_o
);

  // Stage whose write lands in the same cycle as an ALU issued now.
  localparam int WP_IDX = MULT_STAGES - ALU_WB_LAT - 1;

`ifdef VI_MULT_FWD_EN
  localparam logic [MULT_STAGES-1:0] RAW_MASK = 5'b01111;
`else
  localparam logic [MULT_STAGES-1:0] RAW_MASK = 5'b11111;
`endif

  stage_t [MULT_STAGES-1:0]             stg;
  logic   [2:0][REG_AW-1:0]             cmp_addr;
  logic   [2:0][MULT_STAGES-1:0]        cmp_match;
  logic                                 raw_hz, waw_hz, wport_hz, accept;

  // index 0: rs1, 1: rs2, 2: rd (WAW)
  assign cmp_addr = {issue_rd_i, issue_rs2_i, issue_rs1_i};

  for (genvar i = 0; i < 3; i++) begin : g_cmp
    mult_hazard_cmp u_cmp (
      .addr   (cmp_addr[i]),
      .stages (stg),
      .match  (cmp_match[i])
    );
  end

  assign raw_hz   = |((cmp_match[0] | cmp_match[1]) & RAW_MASK);
  assign waw_hz   = issue_we_i && (|cmp_match[2]);
  assign wport_hz = !issue_is_mult_i && issue_we_i && (issue_rd_i != '0) &&
                    stg[WP_IDX].valid && stg[WP_IDX].we;

  assign issue_ready_o = rsn_i && !flush_i && !raw_hz && !waw_hz && !wport_hz;
  assign accept        = issue_valid_i && issue_ready_o && issue_is_mult_i;

`ifdef VI_MULT_FWD_EN
  assign fwd_mult5_rs1_o = issue_valid_i && cmp_match[0][MULT_STAGES-1];
  assign fwd_mult5_rs2_o = issue_valid_i && cmp_match[1][MULT_STAGES-1];
`else
  assign fwd_mult5_rs1_o = 1'b0;
  assign fwd_mult5_rs2_o = 1'b0;
`endif

  // Stage 5 is never killed: its write is already committed this cycle.
  assign mult_kill_o    = {1'b0, {(MULT_STAGES-1){flush_i && rsn_i}}};
  assign wb_sel_mult_o  = stg[MULT_STAGES-1].valid && stg[MULT_STAGES-1].we;
  assign inflight_cnt_o = count_valid(stg);
  assign mult_busy_o    = inflight_cnt_o != '0;

  // Stage tracker: shifts every cycle; flush empties stages 1..4 so
  // nothing reaches stage 5 on the following cycle.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      stg <= '0;
    end else begin
      if (accept) begin
        stg[0].valid <= 1'b1;
        stg[0].rd    <= issue_rd_i;
        stg[0].we    <= issue_we_i && (issue_rd_i != '0);
      end else begin
        stg[0] <= '0;
      end
      for (int k = 1; k < MULT_STAGES; k++)
        stg[k] <= flush_i ? '0 : stg[k-1];
    end
  end

endmodule
